l2_bank_qos_arbiter: RTL

Sequential arbiter for one interleaved L2 memory bank, shared between two master channels: CH0 (clusters) and CH1 (FC/host). It sits between the per-master routing logic and one SRAM bank. It picks at most one request per cycle, using round-robin inside each channel and a starvation-bounded priority of CH1 over CH0. It muxes the winner's request to the bank, tags it with a one-hot ID, and generates the registered per-master response-valid for a bank with fixed 1-cycle read latency.

---
 rtl/l2_bank_qos_arbiter.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/l2_bank_qos_arbiter.sv
// Purpose: arbitrates one L2 bank between CH0 (clusters) and CH1 (FC/host) masters, round-robin per channel, starvation-bounded CH1 priority.
// Latency: grant and bank request are combinational; per-master response valid follows the handshake by exactly 1 cycle.
// Backpressure: data_gnt_i=0 suppresses all grants and freezes pointers and the starvation counter; nothing is buffered.
module l2_bank_qos_arbiter #(
    parameter int N_CH0      = 5,
    parameter int N_CH1      = 4,
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 64,
    parameter int BE_WIDTH   = DATA_WIDTH / 8,
    parameter int ID_WIDTH   = N_CH0 + N_CH1,
    parameter int STARVE_MAX = 15
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic [N_CH0+N_CH1-1:0]                  data_req_i,
    input  logic [(N_CH0+N_CH1)*ADDR_WIDTH-1:0]     data_add_i,
    input  logic [N_CH0+N_CH1-1:0]                  data_wen_i,
    input  logic [(N_CH0+N_CH1)*DATA_WIDTH-1:0]     data_wdata_i,
    input  logic [(N_CH0+N_CH1)*BE_WIDTH-1:0]       data_be_i,
    output logic [N_CH0+N_CH1-1:0]                  data_gnt_o,
    output logic [N_CH0+N_CH1-1:0]                  data_r_valid_o,
    output logic                                    data_req_o,
    output logic [ADDR_WIDTH-1:0]                   data_add_o,
    output logic                                    data_wen_o,
    output logic [DATA_WIDTH-1:0]                   data_wdata_o,
    output logic [BE_WIDTH-1:0]                     data_be_o,
    output logic [ID_WIDTH-1:0]                     data_ID_o,
    input  logic                                    data_gnt_i,
    output logic [$clog2(STARVE_MAX+1)-1:0]         starve_cnt_o
);

    localparam int N_MASTER = N_CH0 + N_CH1;
    localparam int PTR0_W   = (N_CH0 > 1) ? $clog2(N_CH0) : 1;
    localparam int PTR1_W   = (N_CH1 > 1) ? $clog2(N_CH1) : 1;
    localparam int CNT_W    = $clog2(STARVE_MAX + 1);

    // Fields of one bank request, carried as a unit through the winner mux.
    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic                  wen;
        logic [DATA_WIDTH-1:0] wdata;
        logic [BE_WIDTH-1:0]   be;
    } bank_req_t;

    logic [PTR0_W-1:0]   ptr0;
    logic [PTR1_W-1:0]   ptr1;
    logic [CNT_W-1:0]    starve_cnt;
    logic [N_MASTER-1:0] r_valid_q;

    logic [N_MASTER-1:0] req0_pad;
    logic [N_MASTER-1:0] req1_pad;
    logic                ch0_any;
    logic                ch1_any;
    logic                boost;
    logic                sel_ch0;
    logic                hs;
    int                  cand0;
    int                  cand1;
    int                  win_idx;
    logic [N_MASTER-1:0] win_oh;
    bank_req_t           win_req;

    // First requester at channel-relative index >= ptr, wrapping past n-1 to 0.
    // Only meaningful when at least one bit of req[n-1:0] is set.
    function automatic int rr_pick(input logic [N_MASTER-1:0] req, input int ptr, input int n);
        int   idx;
        int   pick;
        logic found;
        pick  = 0;
        found = 1'b0;
        for (int i = 0; i < N_MASTER; i++) begin
            idx = ptr + i;
            if (idx >= n) begin
                idx = idx - n;
            end
            if ((i < n) && !found && req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
        return pick;
    endfunction

    // Channel candidates and inter-channel choice; CH1 wins ties unless CH0 is boosted.
    always_comb begin
        req0_pad = {{N_CH1{1'b0}}, data_req_i[N_CH0-1:0]};
        req1_pad = {{N_CH0{1'b0}}, data_req_i[N_MASTER-1:N_CH0]};
        ch0_any  = |data_req_i[N_CH0-1:0];
        ch1_any  = |data_req_i[N_MASTER-1:N_CH0];
        boost    = (starve_cnt == CNT_W'(STARVE_MAX));
        cand0    = rr_pick(req0_pad, int'(ptr0), N_CH0);
        cand1    = rr_pick(req1_pad, int'(ptr1), N_CH1);
        sel_ch0  = ch0_any && (!ch1_any || boost);
        win_idx  = sel_ch0 ? cand0 : (N_CH0 + cand1);
        win_oh   = '0;
        if (ch0_any || ch1_any) begin
            win_oh[win_idx] = 1'b1;
        end
    end

    // AND-OR mux of the winner's request fields; all zero when nobody requests.
    always_comb begin
        win_req = '0;
        for (int k = 0; k < N_MASTER; k++) begin
            if (win_oh[k]) begin
                win_req.addr  = data_add_i[k*ADDR_WIDTH +: ADDR_WIDTH];
                win_req.wen   = data_wen_i[k];
                win_req.wdata = data_wdata_i[k*DATA_WIDTH +: DATA_WIDTH];
                win_req.be    = data_be_i[k*BE_WIDTH +: BE_WIDTH];
            end
        end
    end

    assign data_req_o   = ch0_any | ch1_any;
    assign hs           = data_req_o & data_gnt_i;
    assign data_gnt_o   = win_oh & {N_MASTER{data_gnt_i}};
    assign data_ID_o    = ID_WIDTH'(win_oh);
    assign data_add_o   = win_req.addr;
    assign data_wen_o   = win_req.wen;
    assign data_wdata_o = win_req.wdata;
    assign data_be_o    = win_req.be;
    assign data_r_valid_o = r_valid_q;
    assign starve_cnt_o = starve_cnt;

    // Round-robin pointers: only the winning channel advances, and only on a handshake.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr0 <= '0;
            ptr1 <= '0;
        end else if (hs) begin
            if (sel_ch0) begin
                ptr0 <= (cand0 == N_CH0 - 1) ? '0 : PTR0_W'(cand0 + 1);
            end else begin
                ptr1 <= (cand1 == N_CH1 - 1) ? '0 : PTR1_W'(cand1 + 1);
            end
        end
    end

    // Starvation counter: counts CH1 handshakes that overtook a waiting CH0, saturating.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (hs && sel_ch0) begin
            starve_cnt <= '0;
        end else if (!ch0_any) begin
            starve_cnt <= '0;
        end else if (hs && (starve_cnt != CNT_W'(STARVE_MAX))) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    // Response valid mirrors the handshake one cycle later (fixed 1-cycle bank latency).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid_q <= '0;
        end else begin
            r_valid_q <= hs ? win_oh : '0;
        end
    end

endmodule
